mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the data access stage (MEM) of the 5-stage pipeline.
- Sequences each access with a request/ready handshake toward memory.
- Prioritises data accesses, with a starvation guard for fetch.
- Drops in-flight fetch results when the pipeline flushes on a branch, JAL or JALR redirect.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width = DATA_W/8
- STREAK_MAX, 4, max consecutive data grants while a fetch waits; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_ready or flush
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_ready  out  1  fetch done; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetch data
- flush  in  1  pipeline redirect; kills pending or in-flight fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_ready  out  1  data done; d_rdata valid for loads
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_be  out  DATA_W/8  registered; all ones for fetch
- mem_ready  in  1  memory completion; mem_rdata valid when high
- mem_rdata  in  DATA_W  memory read data

Behaviour:

States: IDLE, BUSY_I, BUSY_D, BUSY_I_DROP.

Reset (rst_n low at a clock edge):
- State = IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Streak counter = 0.
- if_ready=0 and d_ready=0. Both are combinational from state, so they are 0 in IDLE.
- Reset mid-access abandons the transaction. Memory must tolerate mem_req dropping without ready.

IDLE arbitration (at the clock edge):
- If d_req=1 and NOT (if_req=1 and flush=0 and streak==STREAK_MAX):
  - Grant data; go to BUSY_D.
  - Register mem_* from the d_* inputs.
  - If if_req=1, streak increments, saturating at STREAK_MAX; otherwise streak stays unchanged.
- Else if if_req=1 and flush=0:
  - Grant fetch; go to BUSY_I.
  - mem_we=0, mem_be = all ones, mem_wdata = 0.
  - Streak resets to 0.
- Else stay in IDLE with mem_req=0.

Latency:
- Request seen at edge N → mem_req=1 from cycle N+1.
- All mem_* outputs stay stable until mem_ready=1 is sampled.

Completion (cycle with mem_ready=1):
- BUSY_D: d_ready=1 combinationally, and d_rdata = mem_rdata in the same cycle.
- BUSY_I: if_ready = mem_ready & ~flush, and if_rdata = mem_rdata.
- Next state is always IDLE and mem_req drops, because the requester's req is still high for the completed access on that edge. Minimum 2 cycles per access: grant edge, then at least one BUSY cycle, then one IDLE cycle.

Flush:
- flush=1 in BUSY_I without mem_ready: go to BUSY_I_DROP. Keep mem_req high; the memory access cannot be aborted.
- BUSY_I_DROP: if_ready is held 0. On mem_ready, return to IDLE and discard the data.
- flush=1 in IDLE: a fetch request that cycle is not granted.
- flush has no effect on data accesses.

Other rules:
- if_rdata and d_rdata drive mem_rdata unconditionally; they are meaningful only while the matching ready is high.
- if_ready and d_ready are never high in the same cycle.
- A requester dropping req while in BUSY for its own access is a protocol violation. The arbiter ignores it and completes the access.

Decomposition:
- Shared package cpu_pkg holds:
  - State encoding constants ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_BUSY_I_DROP.
  - ADDR_W and DATA_W defaults.
- Optional sub-module arb_streak_counter: saturating counter with clear and increment, width $clog2(STREAK_MAX+1).
- Everything else stays in one module.

Test Plan:
- Solo fetch: if_req=1, if_addr=0x100, mem_ready after 2 wait cycles with rdata=0x00A00093 → mem_req rises 1 cycle after request; if_ready pulses 1 cycle with if_rdata=0x00A00093; mem_be=0xF, mem_we=0.
- Simultaneous: if_req and d_req both =1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3, mem_ready after 1 cycle → data served first (mem_we=1, mem_be=0x3); fetch is granted at the next IDLE.
- Starvation: d_req held high continuously with if_req=1, STREAK_MAX=4 → exactly 4 data grants, then 1 fetch grant; streak resets; the pattern repeats.
- Flush in flight: fetch granted, flush=1 in the first BUSY cycle, mem_ready 3 cycles later → if_ready never asserts; mem_req stays high until mem_ready; state returns to IDLE.
- Reset mid-access: rst_n=0 while in BUSY_D → next cycle mem_req=0, all mem_* outputs=0, d_ready=0, streak=0.
- Load: d_we=0, d_addr=0x3000, mem_rdata=0x12345678 → d_ready=1 with d_rdata=0x12345678 in the mem_ready cycle; if_ready=0 throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and memory-port arbiter state encoding
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE        = 2'd0;
    localparam arb_state_t ARB_BUSY_I      = 2'd1;
    localparam arb_state_t ARB_BUSY_D      = 2'd2;
    localparam arb_state_t ARB_BUSY_I_DROP = 2'd3;

endpackage

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating count of data grants won while a fetch waits
module arb_streak_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data access
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                flush,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic              streak_clr, streak_inc;
    logic [SW-1:0]     streak;
    logic              fetch_starved;

    arb_streak_counter #(
        .MAX (STREAK_MAX),
        .W   (SW)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (streak_clr),
        .inc   (streak_inc),
        .count (streak)
    );

    // A waiting fetch that has lost STREAK_MAX times in a row wins over data.
    assign fetch_starved = if_req && !flush && (streak == STREAK_LIM);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        streak_clr  = 1'b0;
        streak_inc  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && !fetch_starved) begin
                    state_d     = ARB_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    streak_inc  = if_req;
                end else if (if_req && !flush) begin
                    state_d     = ARB_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_clr  = 1'b1;
                end else begin
                    mem_req_d   = 1'b0;
                end
            end
            ARB_BUSY_I: begin
                if (mem_ready) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end else if (flush) begin
                    state_d   = ARB_BUSY_I_DROP;
                end
            end
            default: begin
                // Data access and dropped fetch both just run to completion.
                if (mem_ready) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    assign if_ready  = (state_q == ARB_BUSY_I) && mem_ready && !flush;
    assign d_ready   = (state_q == ARB_BUSY_D) && mem_ready;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
